// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic stage with valid/ready handshake, chain accumulator
// and accepted-transaction counter. Optional flag outputs: LOGIC_UNIT_FLAGS_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             chain,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             flag_zero,
  output logic             flag_ones
`endif
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] res_p0;
  logic [WIDTH-1:0] res_p1;
  logic [WIDTH-1:0] acc_p1;
  logic [CNT_W-1:0] cnt_p1;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = ~(a & b);
      3'd3:    r = ~(a | b);
      3'd4:    r = a ^ b;
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  assign out_valid = (state_q == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Stage p0: operand select; a clear in the same cycle zeroes the chained operand
  assign a_p0   = chain ? (clear ? '0 : acc_p1) : in_a;
  assign res_p0 = logic_op(op, a_p0, in_b);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Stage p1: result, accumulator and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
      acc_p1 <= '0;
      cnt_p1 <= '0;
    end else if (accept) begin
      res_p1 <= res_p0;
      acc_p1 <= res_p0;
      cnt_p1 <= clear ? CNT_W'(1) : cnt_p1 + CNT_W'(1);
    end else if (clear) begin
      acc_p1 <= '0;
      cnt_p1 <= '0;
    end
  end

  assign out_y    = res_p1;
  assign op_count = cnt_p1;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_p1, ones_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_p1 <= 1'b0;
      ones_p1 <= 1'b0;
    end else if (accept) begin
      zero_p1 <= (res_p0 == '0);
      ones_p1 <= (res_p0 == '1);
    end
  end

  assign flag_zero = zero_p1;
  assign flag_ones = ones_p1;
`endif

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's fixed 2-input gate blocks.
- Applies one of eight bitwise logic operations to two WIDTH-bit operands, selected per transaction.
- Single output register with valid/ready handshake on both sides.
- Chain mode uses the previous result as operand A, so multi-term logic can be folded sequentially.
- Used as the common logic stage in the lab datapath, replacing the individual and/or/nor gate modules.

Parameters:
- WIDTH, 8, operand and result width in bits (>=1).
- CNT_W, 8, width of the accepted-transaction counter (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand transaction present
- in_ready  output  1  block can accept a transaction this cycle
- in_a  input  WIDTH  operand A (ignored when chain=1)
- in_b  input  WIDTH  operand B
- op  input  3  operation select, sampled with the transaction
- chain  input  1  1 = operand A taken from accumulator
- clear  input  1  synchronous clear of accumulator and counter
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  downstream accepts the result
- out_y  output  WIDTH  registered result
- op_count  output  CNT_W  number of accepted transactions, modulo 2^CNT_W

Behaviour:
- Clock, reset and interface:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - On assertion, immediately: out_valid=0, out_y=0, acc=0, op_count=0. in_ready is 1 as soon as reset is released.
  - Reset mid-transaction discards the held result with no output.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A transaction is accepted when in_valid && in_ready.
  - Latency is 1 cycle: the result is on out_y with out_valid=1 on the next edge.
  - Full throughput: one transaction per cycle while out_ready=1.
  - While out_valid && !out_ready, out_y and out_valid hold stable, in_ready=0, and no accept occurs.
  - When out_ready=1 and there is no accept, out_valid goes to 0 next edge and out_y holds its value.
- Operation encoding (A = chain ? acc : in_a, B = in_b):
  - 0: AND
  - 1: OR
  - 2: NAND
  - 3: NOR
  - 4: XOR
  - 5: XNOR
  - 6: NOT A
  - 7: PASS A
- Accumulator:
  - acc is an internal WIDTH-bit register, loaded with the result on every accept, whether chain is 0 or 1.
- Counter:
  - op_count increments by 1 per accept and wraps from 2^CNT_W-1 to 0. No saturation.
- Clear:
  - On a clear=1 cycle without accept: acc=0 and op_count=0 at the next edge. out_y and out_valid are unaffected.
  - clear together with an accept: the operation uses A=0 when chain=1; acc takes the new result; op_count becomes 1.
- State machine (2 states):
  - EMPTY (out_valid=0): go to FULL on accept.
  - FULL (out_valid=1):
    - stay FULL if an accept occurs (requires out_ready);
    - stay FULL if out_ready=0;
    - go to EMPTY if out_ready=1 with no accept.
- Control inputs are ignored when no accept occurs: op, chain, in_a, in_b.

Optional Feature:
- Macro: LOGIC_UNIT_FLAGS_EN.
- When defined, two extra ports are added:
  - flag_zero  output  1
  - flag_ones  output  1
- The flags are registered alongside out_y: flag_zero = (result == 0), flag_ones = (result == all ones).
- The flags reset to 0 and hold with out_y under backpressure.
- When undefined, the ports and their logic are absent and all other behaviour is identical.

Test Plan:
- Reset and basic NOR:
  - Stimulus: WIDTH=8; assert rst_n=0, then release; send op=3, in_a=0x0F, in_b=0x33, out_ready=1.
  - Required: out_y=0xC0 and out_valid=1 one cycle after accept; op_count=1.
- All operations:
  - Stimulus: ops 0..7 back-to-back with in_a=0xF0, in_b=0x3C.
  - Required: results 0x30, 0xFC, 0xCF, 0x03, 0xCC, 0x33, 0x0F, 0xF0 on consecutive cycles; out_valid continuously 1.
- Chain mode:
  - Stimulus: clear; then chain=1, op=1 with in_b=0x01, 0x02, 0x80.
  - Required: out_y=0x01, 0x03, 0x83.
  - Stimulus: then clear together with chain=1, op=1, in_b=0x04.
  - Required: out_y=0x04 and op_count=1.
- Backpressure:
  - Stimulus: hold out_ready=0 after one result of 0xAA.
  - Required: in_ready=0; out_y stays 0xAA for 5 cycles despite in_valid=1 with new data.
  - Stimulus: raise out_ready.
  - Required: next result appears the following cycle; nothing lost or duplicated.
- Counter wrap and async reset:
  - Stimulus: CNT_W=4; 17 accepts.
  - Required: op_count=1.
  - Stimulus: pulse rst_n low mid-cycle while out_valid=1.
  - Required: out_valid, out_y and op_count are 0 before the next clk edge.
- Flags (LOGIC_UNIT_FLAGS_EN):
  - Stimulus: op=3 with in_a=0xFF, in_b=0x00.
  - Required: out_y=0x00, flag_zero=1, flag_ones=0.
  - Stimulus: op=2 with in_a=0x00, in_b=0x00.
  - Required: out_y=0xFF, flag_ones=1.
